// File: rtl/param_serial_transmitter.sv
// Parameterised serial transmitter: a one-word holding buffer in front of a shift
// register, emitting DATA_WIDTH bits per frame with a mid-bit rising bit clock.
module param_serial_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ready,
  output logic                  transmission,
  output logic                  transmission_clock,
  output logic                  out_data,
  output logic                  frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    transmission_q, tclk_q, out_q, done_q;
  logic                    xfer_s, last_s, sel_bit_s;

  assign ready              = !hold_valid_q;
  assign transmission       = transmission_q;
  assign transmission_clock = tclk_q;
  assign out_data           = out_q;
  assign frame_done         = done_q;

  // Next-state logic: frame sequencing, buffer refill and bit shifting.
  always_comb begin
    xfer_s       = send && !hold_valid_q;
    last_s       = (bit_q == BIT_LAST) && (div_q == DIV_LAST);
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bit_d        = bit_q;
    div_d        = div_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d = SHIFT;
          shift_d = in_data;
          bit_d   = '0;
          div_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          bit_d = '0;
          div_d = '0;
          // A pending word always wins; ready is low then, so no direct load can collide.
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
          end else if (xfer_s) begin
            shift_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            bit_d = bit_q + BIT_W'(1);
            if (LSB_FIRST != 0) begin
              shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end else begin
              shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (xfer_s) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
          end else begin
            hold_valid_d = hold_valid_q;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        hold_valid_d = 1'b0;
        bit_d        = '0;
        div_d        = '0;
      end
    endcase
    sel_bit_s = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_WIDTH-1];
  end

  // State registers; line outputs are registered from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_valid_q   <= 1'b0;
      bit_q          <= '0;
      div_q          <= '0;
      transmission_q <= 1'b0;
      tclk_q         <= 1'b0;
      out_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      hold_valid_q   <= hold_valid_d;
      bit_q          <= bit_d;
      div_q          <= div_d;
      transmission_q <= (state_d == SHIFT);
      tclk_q         <= (state_d == SHIFT) && (div_d >= DIV_HALF);
      out_q          <= (state_d == SHIFT) && sel_bit_s;
      done_q         <= (state_d == SHIFT) && (bit_d == BIT_LAST) && (div_d == DIV_LAST);
    end
  end

endmodule

// File: tb/tb_param_serial_transmitter.sv
// Bench for param_serial_transmitter: eight instances (default, MSB-first, sweep)
// checked every cycle against a frame-level reference model plus directed sequences.
module tb_param_serial_transmitter;

  localparam int NI = 8;

  function automatic int dw_of(input int i);
    case (i)
      0, 1:    return 8;
      2, 3:    return 2;
      4, 5:    return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cd_of(input int i);
    case (i)
      0, 1:    return 4;
      2, 4, 6: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int lsb_of(input int i);
    case (i)
      1, 5, 7: return 0;
      default: return 1;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        send_v [NI];
  logic [31:0] data_v [NI];
  logic        rdy_v  [NI];
  logic        tx_v   [NI];
  logic        tclk_v [NI];
  logic        od_v   [NI];
  logic        fd_v   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    param_serial_transmitter #(
      .DATA_WIDTH(dw_of(g)),
      .CLK_DIV   (cd_of(g)),
      .LSB_FIRST (lsb_of(g))
    ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .send              (send_v[g]),
      .in_data           (data_v[g][dw_of(g)-1:0]),
      .ready             (rdy_v[g]),
      .transmission      (tx_v[g]),
      .transmission_clock(tclk_v[g]),
      .out_data          (od_v[g]),
      .frame_done        (fd_v[g])
    );
  end

  int n_run = 0;
  int n_fail = 0;

  // Reference model: active frame word, cycle index within frame, one pending word.
  bit          m_act  [NI];
  int          m_t    [NI];
  logic [31:0] m_word [NI];
  logic [31:0] m_hold [NI];
  bit          m_pend [NI];
  int          m_acc  [NI];
  // Receiver emulation sampling out_data on transmission_clock rising edges.
  logic [31:0] rx_word   [NI];
  int          rx_cnt    [NI];
  int          rx_frames [NI];
  logic        prev_tclk [NI];

  typedef struct {
    int   cyc;
    logic tx, tclk, od, fd, rdy, od1;
  } vec_t;
  vec_t tab [9];

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d time=%0t got=%0h expected=%0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int          dw, cd, len, pos;
      logic [4:0]  exp_v;
      logic [31:0] mask, din;
      bit          xfer;
      dw   = dw_of(i);
      cd   = cd_of(i);
      len  = dw * cd;
      mask = 32'((64'd1 << dw) - 64'd1);
      pos  = (lsb_of(i) != 0) ? (m_t[i] / cd) : (dw - 1 - m_t[i] / cd);
      exp_v = {!m_pend[i], m_act[i], m_act[i] && ((m_t[i] % cd) >= (cd / 2)),
               m_act[i] && m_word[i][pos], m_act[i] && (m_t[i] == len - 1)};
      check("outs", i, 64'({rdy_v[i], tx_v[i], tclk_v[i], od_v[i], fd_v[i]}), 64'(exp_v));
      if (tclk_v[i] === 1'b1 && prev_tclk[i] !== 1'b1) begin
        int p;
        p = (lsb_of(i) != 0) ? rx_cnt[i] : (dw - 1 - rx_cnt[i]);
        if (p >= 0 && p < 32) rx_word[i][p] = od_v[i];
        rx_cnt[i]++;
      end
      prev_tclk[i] = tclk_v[i];
      if (fd_v[i] === 1'b1) begin
        check("rxword", i, {32'(rx_cnt[i]), rx_word[i]}, {32'(dw), m_word[i]});
        rx_frames[i]++;
        rx_cnt[i]  = 0;
        rx_word[i] = '0;
      end
      if (rst) begin
        m_act[i]   = 1'b0;
        m_pend[i]  = 1'b0;
        rx_cnt[i]  = 0;
        rx_word[i] = '0;
      end else begin
        xfer = send_v[i] && !m_pend[i];
        din  = data_v[i] & mask;
        if (!m_act[i]) begin
          if (xfer) begin
            m_act[i] = 1'b1; m_word[i] = din; m_t[i] = 0; m_acc[i]++;
          end
        end else if (m_t[i] == len - 1) begin
          if (m_pend[i]) begin
            m_word[i] = m_hold[i]; m_pend[i] = 1'b0; m_t[i] = 0;
          end else if (xfer) begin
            m_word[i] = din; m_t[i] = 0; m_acc[i]++;
          end else begin
            m_act[i] = 1'b0;
          end
        end else begin
          m_t[i]++;
          if (xfer) begin
            m_hold[i] = din; m_pend[i] = 1'b1; m_acc[i]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle_inputs();
    for (int i = 0; i < NI; i++) begin
      send_v[i] = 1'b0;
      data_v[i] = '0;
    end
  endtask

  initial begin
    int tx_c, fd_c, acc0, rxf0;
    int fd_pos [2];
    int tx_cnt [NI];

    tab[0] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[1] = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[2] = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[3] = '{11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[4] = '{24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[5] = '{28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[6] = '{31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[7] = '{32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[8] = '{33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0; m_pend[i] = 1'b0; m_t[i] = 0; m_word[i] = '0; m_hold[i] = '0;
      m_acc[i] = 0; rx_word[i] = '0; rx_cnt[i] = 0; rx_frames[i] = 0; prev_tclk[i] = 1'b0;
    end
    all_idle_inputs();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    check("reset_outs", 0, 64'({rdy_v[0], tx_v[0], tclk_v[0], od_v[0], fd_v[0]}), 64'(5'b10000));
    rst = 1'b0;
    tick();

    // Single frame on every instance: A5 LSB-first, 80 MSB-first, random on the sweep
    for (int i = 0; i < NI; i++) begin
      send_v[i] = 1'b1;
      data_v[i] = (i == 0) ? 32'hA5 : (i == 1) ? 32'h80 : $urandom;
      tx_cnt[i] = 0;
    end
    tick();
    all_idle_inputs();
    for (int c = 1; c <= 300; c++) begin
      for (int k = 0; k < 9; k++) begin
        if (tab[k].cyc == c) begin
          check("vec", k, 64'({tx_v[0], tclk_v[0], od_v[0], fd_v[0], rdy_v[0], od_v[1]}),
                64'({tab[k].tx, tab[k].tclk, tab[k].od, tab[k].fd, tab[k].rdy, tab[k].od1}));
        end
      end
      for (int i = 0; i < NI; i++) tx_cnt[i] += int'(tx_v[i]);
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      check("frame_len", i, 64'(tx_cnt[i]), 64'(dw_of(i) * cd_of(i)));
    end

    // Back-to-back 01 then FF
    send_v[0] = 1'b1; data_v[0] = 32'h01;
    tick();
    tx_c = 0; fd_c = 0; fd_pos[0] = -1; fd_pos[1] = -1;
    for (int c = 0; c < 80; c++) begin
      send_v[0] = (c == 0);
      data_v[0] = (c == 0) ? 32'hFF : 32'(c);
      if (c == 1)  check("b2b_ready_low", 0, 64'(rdy_v[0]), 64'd0);
      if (c == 31) check("b2b_ready_held", 0, 64'(rdy_v[0]), 64'd0);
      if (c == 32) check("b2b_ready_back", 0, 64'(rdy_v[0]), 64'd1);
      tx_c += int'(tx_v[0]);
      if (fd_v[0]) begin
        if (fd_c < 2) fd_pos[fd_c] = c;
        fd_c++;
      end
      tick();
    end
    check("b2b_tx_cycles", 0, 64'(tx_c), 64'd64);
    check("b2b_done_count", 0, 64'(fd_c), 64'd2);
    check("b2b_done_first", 0, 64'(fd_pos[0]), 64'd31);
    check("b2b_done_gap", 0, 64'(fd_pos[1] - fd_pos[0]), 64'd32);
    all_idle_inputs();

    // Send held high for 100 cycles with 3C
    acc0 = m_acc[0];
    rxf0 = rx_frames[0];
    for (int c = 0; c < 100; c++) begin
      send_v[0] = 1'b1; data_v[0] = 32'h3C;
      tick();
    end
    all_idle_inputs();
    for (int c = 0; c < 80; c++) tick();
    check("held_accepts", 0, 64'(m_acc[0] - acc0), 64'd5);
    check("held_frames", 0, 64'(rx_frames[0] - rxf0), 64'(m_acc[0] - acc0));

    // Reset mid-frame with a held word pending
    send_v[0] = 1'b1; data_v[0] = 32'hFF;
    tick();
    data_v[0] = 32'h55;
    tick();
    send_v[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      data_v[0] = $urandom;
      tick();
    end
    check("rst_pre_tx", 0, 64'(tx_v[0]), 64'd1);
    rst = 1'b1; send_v[0] = 1'b1; data_v[0] = 32'hAA;
    tick();
    check("rst_outs", 0, 64'({rdy_v[0], tx_v[0], tclk_v[0], od_v[0], fd_v[0]}), 64'(5'b10000));
    rst = 1'b0; send_v[0] = 1'b0;
    tx_c = 0;
    for (int c = 0; c < 60; c++) begin
      tx_c += int'(tx_v[0]);
      tick();
    end
    check("rst_no_held_tx", 0, 64'(tx_c), 64'd0);

    // Randomised traffic on all instances with occasional reset
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NI; i++) begin
        send_v[i] = ($urandom_range(0, 2) == 0);
        data_v[i] = $urandom;
      end
      tick();
    end
    rst = 1'b0;
    all_idle_inputs();
    for (int c = 0; c < 600; c++) tick();
    for (int i = 0; i < NI; i++) check("drained", i, 64'(tx_v[i]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/param_serial_transmitter.md
PARAM_SERIAL_TRANSMITTER -- requirements
Module: param_serial_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per frame; legal range 2..32.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per serial bit; even, legal range 2..256.
REQ-003 Parameter LSB_FIRST, default 1: 1 = bit 0 sent first, 0 = bit DATA_WIDTH-1 sent first.
REQ-004 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port send, input, 1: word-valid; a transfer occurs on an edge where send && ready.
REQ-007 Port in_data, input, DATA_WIDTH: word to serialise; sampled only on a transfer edge.
REQ-008 Port ready, output, 1: high when a word can be accepted this cycle.
REQ-009 Port transmission, output, 1: high while a frame is on the line.
REQ-010 Port transmission_clock, output, 1: bit clock for the receiver, which samples on its rising edge.
REQ-011 Port out_data, output, 1: current serial bit.
REQ-012 Port frame_done, output, 1: one-cycle pulse on the final clk cycle of each frame.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT, with a shift register, a one-entry holding register (hold_valid flag), a bit counter and a divider counter.
REQ-014 ready SHALL equal !hold_valid, combinationally; ready is therefore always 1 in IDLE.
REQ-015 Transfer in IDLE: at that edge, in_data SHALL load the shift register directly, the state SHALL become SHIFT, both counters SHALL clear, and transmission=1 SHALL hold from the next cycle on.
REQ-016 Transfer in SHIFT: in_data SHALL be written into the holding register and hold_valid SHALL be set.
REQ-017 Each bit SHALL last exactly CLK_DIV cycles, so a frame lasts DATA_WIDTH*CLK_DIV cycles.
REQ-018 Within a bit, transmission_clock SHALL be 0 for the first CLK_DIV/2 cycles and 1 for the remaining CLK_DIV/2 cycles; the rising edge is mid-bit.
REQ-019 out_data SHALL present shift-register bit 0 (LSB_FIRST=1) or bit DATA_WIDTH-1 (LSB_FIRST=0), constant for the whole bit period.
REQ-020 frame_done SHALL be 1 only on the cycle where bit counter = DATA_WIDTH-1 and divider counter = CLK_DIV-1.
REQ-021 At frame end with hold_valid=1, the holding register SHALL move to the shift register, hold_valid SHALL clear and the FSM SHALL stay in SHIFT with transmission remaining 1, giving zero idle gap.
REQ-022 At frame end with hold_valid=0 and a transfer on that same edge, in_data SHALL load the shift register directly and the next frame SHALL proceed as in REQ-021.
REQ-023 At frame end with hold_valid=0 and no transfer, the FSM SHALL return to IDLE.
REQ-024 In IDLE, transmission, transmission_clock, out_data and frame_done SHALL all be 0.
REQ-025 Counters SHALL wrap the divider counter at CLK_DIV-1 and the bit counter at DATA_WIDTH-1; no other wrap is permitted.
REQ-026 Changes on in_data while no transfer occurs SHALL NOT affect the frame in flight or the held word.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, clear hold_valid, both counters and the shift register, and drop any frame in progress immediately.
REQ-028 After reset: ready=1, transmission=0, transmission_clock=0, out_data=0, frame_done=0.
REQ-029 rst SHALL take priority over a simultaneous transfer, which is discarded.

Verification (DATA_WIDTH=8, CLK_DIV=4, LSB_FIRST=1 unless stated)
REQ-030 Single frame: send=1 for one cycle with 8'hA5 from IDLE -> transmission high for 32 cycles; sampling out_data at the transmission_clock rising edges gives 1,0,1,0,0,1,0,1; frame_done pulses once at cycle 32; then IDLE.
REQ-031 Back-to-back: 8'h01 is sent, and 8'hFF is sent during that frame -> ready=0 after the second transfer; transmission stays 1 for 64 cycles with no gap; frame_done pulses twice, 32 cycles apart; ready returns to 1 when 8'hFF starts shifting.
REQ-032 Held send: send held at 1 for 100 cycles with in_data=8'h3C -> only transfers with ready=1 occur; continuous frames; no word lost or duplicated relative to the transfer count.
REQ-033 MSB-first: LSB_FIRST=0 with 8'h80 -> the first sampled bit is 1 and the remaining 7 bits are 0.
REQ-034 Reset mid-frame: rst=1 at bit 3 of frame 8'hFF with a held word pending -> the next cycle shows all outputs 0 and ready=1; the held word is never transmitted.
REQ-035 Parameter sweep: DATA_WIDTH in {2,16,32} x CLK_DIV in {2,8} -> frame length = DATA_WIDTH*CLK_DIV cycles and the bit order is correct.
